playfield_clear_ctrl: RTL and testbench
=======================================

PLAYFIELD_CLEAR_CTRL -- requirements
Module: playfield_clear_ctrl

Interface
REQ-001 SHALL have parameter PLAYFIELD_ROWS, default 20, meaning the number of playfield rows; row 0 is the top row and row ROWS-1 is the bottom row.
REQ-002 SHALL have parameter PLAYFIELD_COLS, default 10, meaning the number of tiles per row.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to run a line-clear pass; it is sampled only in IDLE.
REQ-006 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have port done, output, 1 bit: a one-cycle pulse at the end of a pass.
REQ-008 SHALL have port lines_cleared, output, 5 bits: the full-row count of the last pass, held until the next start.
REQ-009 SHALL have port mem_row, output, 5 bits: tile RAM row address.
REQ-010 SHALL have port mem_col, output, 4 bits: tile RAM column address.
REQ-011 SHALL have port mem_re, output, 1 bit: tile RAM read enable; read data has 1-cycle latency.
REQ-012 SHALL have port mem_we, output, 1 bit: tile RAM write enable.
REQ-013 SHALL have port mem_wdata, output, tile_type_t (4 bits): tile RAM write data.
REQ-014 SHALL have port mem_rdata, input, tile_type_t (4 bits): tile RAM read data.

Function
REQ-015 SHALL implement the states IDLE, READ, EVAL, WRITE, FILL and DONE.
REQ-016 SHALL keep rd_row and wr_row pointers (both start at ROWS-1), a column counter, a ROWS-1 rows-remaining count, a PLAYFIELD_COLS-entry tile buffer and a full flag.
REQ-017 SHALL in IDLE with start=1 set rd_row=wr_row=ROWS-1, clear the column counter, set the full flag, clear the clear count and go to READ next cycle.
REQ-018 SHALL in READ drive mem_re=1, mem_row=rd_row and mem_col=col for col=0..COLS-1, one column per cycle, then go to EVAL.
REQ-019 SHALL capture mem_rdata into buffer[col-1] one cycle after each read; the last capture happens in EVAL.
REQ-020 SHALL treat a captured tile equal to BLANK or GHOST as not-filled; any such tile clears the full flag.
REQ-021 SHALL in EVAL, with the row full: increment the clear count, decrement rd_row and leave wr_row unchanged.
REQ-022 SHALL in EVAL, with the row not full and wr_row==rd_row: decrement both pointers and skip WRITE.
REQ-023 SHALL in EVAL, with the row not full and wr_row!=rd_row: go to WRITE.
REQ-024 SHALL in WRITE drive mem_we=1, mem_row=wr_row, mem_col=col and mem_wdata=buffer[col] for col=0..COLS-1 over COLS cycles, then decrement both pointers.
REQ-025 SHALL after EVAL or WRITE return to READ with the full flag set if rows remain to read.
REQ-026 SHALL after the row-0 evaluation go to FILL if the clear count is nonzero, else to DONE.
REQ-027 SHALL in FILL write BLANK to all COLS columns of wr_row, decrementing wr_row after each row, until row 0 is written; then go to DONE.
REQ-028 SHALL in DONE assert done=1 for one cycle, register the clear count into lines_cleared and return to IDLE.
REQ-029 SHALL never assert mem_re and mem_we in the same cycle.
REQ-030 SHALL drive mem_row, mem_col and mem_wdata to 0 when the RAM is idle.
REQ-031 SHALL ignore start while busy.
REQ-032 SHALL detect pointer underflow with the rows-remaining count, not with a negative pointer value.
REQ-033 SHALL produce no RAM accesses other than those defined in REQ-018, REQ-024 and REQ-027.
REQ-034 SHALL take 20*(COLS+1)+1 = 221 cycles from start to done for a pass with no full rows.

Reset
REQ-035 SHALL on rst=1 go to IDLE and drive busy=0, done=0, lines_cleared=0, mem_re=0, mem_we=0, mem_row=0, mem_col=0 and mem_wdata=BLANK.
REQ-036 SHALL on rst in mid-pass abandon the pass without a done pulse; the RAM contents are then undefined.

Verification
REQ-037 SHALL cover: empty playfield, start -> 200 reads, 0 writes, done at cycle 221, lines_cleared=0.
REQ-038 SHALL cover: row 19 all GARBAGE, row 18 one T at col 3, start -> row 18 written to row 19, row 0 filled BLANK, lines_cleared=1.
REQ-039 SHALL cover: rows 16-19 full, rows 14-15 partial -> rows 14-15 moved to rows 18-19, rows 0-3 BLANK, lines_cleared=4.
REQ-040 SHALL cover: row 19 full except one GHOST tile -> not cleared, lines_cleared=0.
REQ-041 SHALL cover: rst asserted during WRITE, then start again -> clean pass with done and no spurious writes after rst.
REQ-042 SHALL cover: start pulsed while busy -> ignored, exactly one done pulse.

Source files
------------

// File: rtl/playfield_clear_ctrl.sv
// rtl/playfield_clear_ctrl.sv - line-clear sequencer for the tile playfield RAM
//
// Purpose: walks the playfield from the bottom row up. Each row is read into a
// one-row buffer and evaluated. Full rows are dropped. Surviving rows are
// copied down over the dropped ones. The rows left over at the top are then
// filled with BLANK.
//
// Ports:
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   start         : one-cycle pass request, honoured only in IDLE
//   busy          : high whenever the FSM is not in IDLE
//   done          : one-cycle pulse at the end of a pass
//   lines_cleared : full-row count of the last completed pass
//   mem_row       : tile RAM row address
//   mem_col       : tile RAM column address
//   mem_re        : tile RAM read enable (read data arrives one cycle later)
//   mem_we        : tile RAM write enable
//   mem_wdata     : tile RAM write data
//   mem_rdata     : tile RAM read data

package playfield_clear_ctrl_pkg;
  typedef enum logic [3:0] {
    BLANK   = 4'd0,
    I       = 4'd1,
    O       = 4'd2,
    T       = 4'd3,
    S       = 4'd4,
    Z       = 4'd5,
    J       = 4'd6,
    L       = 4'd7,
    GARBAGE = 4'd8,
    GHOST   = 4'd9
  } tile_type_t;
endpackage

module playfield_clear_ctrl
  import playfield_clear_ctrl_pkg::*;
#(
  parameter int PLAYFIELD_ROWS = 20,
  parameter int PLAYFIELD_COLS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [4:0] lines_cleared,
  output logic [4:0] mem_row,
  output logic [3:0] mem_col,
  output logic       mem_re,
  output logic       mem_we,
  output tile_type_t mem_wdata,
  input  tile_type_t mem_rdata
);

  localparam logic [4:0] ROW_LAST = 5'(PLAYFIELD_ROWS - 1);
  localparam logic [3:0] COL_LAST = 4'(PLAYFIELD_COLS - 1);

  typedef enum logic [2:0] {IDLE, READ, EVAL, WRITE, FILL, DONE} state_t;

  state_t     state_q, state_d;
  logic [4:0] rd_row_q, rd_row_d;
  logic [4:0] wr_row_q, wr_row_d;
  logic [3:0] col_q, col_d;
  logic [4:0] rows_left_q, rows_left_d;
  logic [4:0] clr_cnt_q, clr_cnt_d;
  logic [4:0] lines_q, lines_d;
  logic       full_q, full_d;

  // Read data lags the address by one cycle, so the capture slot and column
  // are carried along with it.
  logic       rd_pend_q;
  logic [3:0] rd_idx_q;
  tile_type_t buf_q [PLAYFIELD_COLS];

  logic       tile_filled;
  logic       advance;

  assign tile_filled   = (mem_rdata != BLANK) && (mem_rdata != GHOST);
  assign lines_cleared = lines_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_row_q    <= ROW_LAST;
      wr_row_q    <= ROW_LAST;
      col_q       <= 4'd0;
      rows_left_q <= 5'd0;
      clr_cnt_q   <= 5'd0;
      lines_q     <= 5'd0;
      full_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_row_q    <= rd_row_d;
      wr_row_q    <= wr_row_d;
      col_q       <= col_d;
      rows_left_q <= rows_left_d;
      clr_cnt_q   <= clr_cnt_d;
      lines_q     <= lines_d;
      full_q      <= full_d;
      rd_pend_q   <= (state_q == READ);
    end
  end

  always_ff @(posedge clk) begin
    rd_idx_q <= col_q;
    if (rd_pend_q) begin
      buf_q[rd_idx_q] <= mem_rdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_row_d    = rd_row_q;
    wr_row_d    = wr_row_q;
    col_d       = col_q;
    rows_left_d = rows_left_q;
    clr_cnt_d   = clr_cnt_q;
    lines_d     = lines_q;
    full_d      = full_q;
    advance     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_row     = 5'd0;
    mem_col     = 4'd0;
    mem_wdata   = BLANK;

    // The final capture of a row lands in EVAL, so full_d (not full_q) is the
    // verdict EVAL must use.
    if (rd_pend_q && !tile_filled) begin
      full_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          rd_row_d    = ROW_LAST;
          wr_row_d    = ROW_LAST;
          col_d       = 4'd0;
          rows_left_d = ROW_LAST;
          clr_cnt_d   = 5'd0;
          full_d      = 1'b1;
          state_d     = READ;
        end
      end

      READ: begin
        mem_re  = 1'b1;
        mem_row = rd_row_q;
        mem_col = col_q;
        if (col_q == COL_LAST) begin
          col_d   = 4'd0;
          state_d = EVAL;
        end else begin
          col_d = col_q + 4'd1;
        end
      end

      EVAL: begin
        if (full_d) begin
          clr_cnt_d = clr_cnt_q + 5'd1;
          rd_row_d  = rd_row_q - 5'd1;
          advance   = 1'b1;
        end else if (wr_row_q == rd_row_q) begin
          // Row already sits where it belongs; no copy needed.
          rd_row_d = rd_row_q - 5'd1;
          wr_row_d = wr_row_q - 5'd1;
          advance  = 1'b1;
        end else begin
          state_d = WRITE;
        end
      end

      WRITE: begin
        mem_we    = 1'b1;
        mem_row   = wr_row_q;
        mem_col   = col_q;
        mem_wdata = buf_q[col_q];
        if (col_q == COL_LAST) begin
          col_d    = 4'd0;
          rd_row_d = rd_row_q - 5'd1;
          wr_row_d = wr_row_q - 5'd1;
          advance  = 1'b1;
        end else begin
          col_d = col_q + 4'd1;
        end
      end

      FILL: begin
        mem_we  = 1'b1;
        mem_row = wr_row_q;
        mem_col = col_q;
        if (col_q == COL_LAST) begin
          col_d    = 4'd0;
          wr_row_d = wr_row_q - 5'd1;
          if (wr_row_q == 5'd0) begin
            state_d = DONE;
          end
        end else begin
          col_d = col_q + 4'd1;
        end
      end

      DONE: begin
        done    = 1'b1;
        lines_d = clr_cnt_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Row 0 is the last row to evaluate when rows_left reaches zero; the
    // pointers themselves may wrap harmlessly past it.
    if (advance) begin
      if (rows_left_q != 5'd0) begin
        rows_left_d = rows_left_q - 5'd1;
        full_d      = 1'b1;
        state_d     = READ;
      end else if (clr_cnt_d != 5'd0) begin
        state_d = FILL;
      end else begin
        state_d = DONE;
      end
    end
  end

endmodule

// File: tb/tb_playfield_clear_ctrl.sv
// tb/tb_playfield_clear_ctrl.sv - directed bench for playfield_clear_ctrl

module tb_playfield_clear_ctrl;
  import playfield_clear_ctrl_pkg::*;

  localparam int ROWS = 20;
  localparam int COLS = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic [4:0] lines_cleared;
  logic [4:0] mem_row;
  logic [3:0] mem_col;
  logic       mem_re;
  logic       mem_we;
  tile_type_t mem_wdata;
  tile_type_t mem_rdata;

  tile_type_t ram     [ROWS][COLS];
  tile_type_t exp_ram [ROWS][COLS];

  int n_chk = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int both_cnt = 0;

  playfield_clear_ctrl #(.PLAYFIELD_ROWS(ROWS), .PLAYFIELD_COLS(COLS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .lines_cleared(lines_cleared),
    .mem_row      (mem_row),
    .mem_col      (mem_col),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we && int'(mem_row) < ROWS && int'(mem_col) < COLS)
      ram[mem_row][mem_col] <= mem_wdata;
    if (mem_re)
      mem_rdata <= (int'(mem_row) < ROWS && int'(mem_col) < COLS) ? ram[mem_row][mem_col] : BLANK;
  end

  always @(negedge clk) begin
    if (mem_re) rd_cnt++;
    if (mem_we) wr_cnt++;
    if (done) done_cnt++;
    if (mem_re && mem_we) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ram_row(input int r);
    logic [63:0] v = '0;
    for (int c = 0; c < COLS; c++) v[c*4 +: 4] = ram[r][c];
    return v;
  endfunction

  function automatic logic [63:0] exp_row(input int r);
    logic [63:0] v = '0;
    for (int c = 0; c < COLS; c++) v[c*4 +: 4] = exp_ram[r][c];
    return v;
  endfunction

  task automatic load_blank();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        ram[r][c]     = BLANK;
        exp_ram[r][c] = BLANK;
      end
  endtask

  task automatic check_mem(input string tag);
    for (int r = 0; r < ROWS; r++)
      check_eq($sformatf("%s_row%0d", tag, r), ram_row(r), exp_row(r));
  endtask

  // Row 19 all GARBAGE, row 18 a single T at col 3: one clear, T lands on row 19.
  task automatic load_case_t();
    load_blank();
    for (int c = 0; c < COLS; c++) ram[19][c] = GARBAGE;
    ram[18][3]     = T;
    exp_ram[19][3] = T;
  endtask

  // Called at a negedge with the DUT idle; returns cycles from start to done.
  task automatic run_pass(input string tag, input int extra_at, output int cycles);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    while (!done && cycles < 2000) begin
      start = (extra_at != 0 && cycles == extra_at);
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, done, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  int cyc, r0, w0, d0, w1, waited;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    load_blank();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy",  busy, 0);
    check_eq("rst_done",  done, 0);
    check_eq("rst_lines", lines_cleared, 0);
    check_eq("rst_re",    mem_re, 0);
    check_eq("rst_we",    mem_we, 0);
    check_eq("rst_row",   mem_row, 0);
    check_eq("rst_col",   mem_col, 0);
    check_eq("rst_wdata", mem_wdata, BLANK);
    rst = 1'b0;
    @(negedge clk);

    // Empty playfield
    load_blank();
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
    run_pass("empty", 0, cyc);
    check_eq("empty_cycles", cyc, 221);
    check_eq("empty_reads", rd_cnt - r0, 200);
    check_eq("empty_writes", wr_cnt - w0, 0);
    check_eq("empty_dones", done_cnt - d0, 1);
    check_eq("empty_lines", lines_cleared, 0);
    check_eq("empty_busy", busy, 0);
    check_mem("empty");

    // One full row, T drops into it
    load_case_t();
    w0 = wr_cnt;
    run_pass("one", 0, cyc);
    check_eq("one_lines", lines_cleared, 1);
    check_eq("one_writes", wr_cnt - w0, 200);
    check_mem("one");

    // Four full rows, two partial rows fall to the bottom
    load_blank();
    for (int r = 16; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) ram[r][c] = GARBAGE;
    ram[15][0] = I;
    ram[14][1] = O;
    ram[14][2] = O;
    exp_ram[19][0] = I;
    exp_ram[18][1] = O;
    exp_ram[18][2] = O;
    run_pass("four", 0, cyc);
    check_eq("four_lines", lines_cleared, 4);
    check_mem("four");

    // GHOST counts as a hole
    load_blank();
    for (int c = 0; c < COLS; c++) begin
      ram[19][c]     = (c == 5) ? GHOST : GARBAGE;
      exp_ram[19][c] = (c == 5) ? GHOST : GARBAGE;
    end
    w0 = wr_cnt;
    run_pass("ghost", 0, cyc);
    check_eq("ghost_lines", lines_cleared, 0);
    check_eq("ghost_writes", wr_cnt - w0, 0);
    check_eq("ghost_cycles", cyc, 221);
    check_mem("ghost");

    // Reset during WRITE, then a clean pass
    load_case_t();
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    waited = 0;
    while (!mem_we && waited < 500) begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    check_eq("rstw_saw_write", mem_we, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstw_busy", busy, 0);
    check_eq("rstw_lines", lines_cleared, 0);
    w1 = wr_cnt;
    repeat (5) @(negedge clk);
    check_eq("rstw_no_writes", wr_cnt - w1, 0);
    check_eq("rstw_no_done", done_cnt - d0, 0);
    load_case_t();
    d0 = done_cnt;
    run_pass("rstw_again", 0, cyc);
    check_eq("rstw_again_dones", done_cnt - d0, 1);
    check_eq("rstw_again_lines", lines_cleared, 1);
    check_mem("rstw_again");

    // Start pulsed while busy is ignored
    load_blank();
    d0 = done_cnt;
    run_pass("busy_start", 50, cyc);
    check_eq("busy_start_cycles", cyc, 221);
    repeat (5) @(negedge clk);
    check_eq("busy_start_dones", done_cnt - d0, 1);
    check_eq("busy_start_idle", busy, 0);

    check_eq("re_we_overlap", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
